// File: rtl/reg_file.sv
// rtl/reg_file.sv - RV32I register file with write-through bypass and pending-writeback scoreboard
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ad1,
  input  logic [ADDR_WIDTH-1:0] ad2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] ad3,
  input  logic [DATA_WIDTH-1:0] wd3,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  hazard,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic                  wr_en;
  logic                  issue_en;
  logic                  hz1;
  logic                  hz2;

  assign wr_en    = we3 && (ad3 != '0);
  assign issue_en = issue && (issue_rd != '0);

  // Set is applied after clear so a producer issued in the writeback cycle keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) begin
      pending_nxt[ad3] = 1'b0;
    end
    if (issue_en) begin
      pending_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[ad3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ad1 != '0) begin
      rd1 = (we3 && (ad3 == ad1)) ? wd3 : regs[ad1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ad2 != '0) begin
      rd2 = (we3 && (ad3 == ad2)) ? wd3 : regs[ad2];
    end
  end

  // A same-cycle writeback to the operand is covered by the bypass, so it is not a hazard.
  always_comb begin
    hz1 = (ad1 != '0) && pending[ad1] && !(we3 && (ad3 == ad1));
    hz2 = (ad2 != '0) && pending[ad2] && !(we3 && (ad3 == ad2));
  end

  assign hazard = hz1 || hz2;

  generate
    if (ADDR_WIDTH >= 4) begin : g_a0
      localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a0 <= '0;
        end else if (wr_en && (ad3 == A0_IDX)) begin
          a0 <= wd3;
        end else begin
          a0 <= regs[10];
        end
      end
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against a behavioural model
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ad1, ad2, ad3, issue_rd;
  logic [31:0] rd1, rd2, wd3, a0;
  logic        we3, issue, hazard;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: architectural state after the last edge
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_a0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ad1(ad1), .ad2(ad2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .ad3(ad3), .wd3(wd3),
    .issue(issue), .issue_rd(issue_rd),
    .hazard(hazard), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_a0 = 32'd0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we3 && ad3 == a) return wd3;
    return m_regs[a];
  endfunction

  function automatic logic exp_hz();
    logic h;
    h = 1'b0;
    if (ad1 != 5'd0 && m_pend[ad1] && !(we3 && ad3 == ad1)) h = 1'b1;
    if (ad2 != 5'd0 && m_pend[ad2] && !(we3 && ad3 == ad2)) h = 1'b1;
    return h;
  endfunction

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                       input logic [4:0] a3, input logic [31:0] d,
                       input logic iss, input logic [4:0] ird);
    ad1 = a1; ad2 = a2; we3 = w; ad3 = a3; wd3 = d; issue = iss; issue_rd = ird;
  endtask

  // advance one edge and apply the architectural rules to the model
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we3 && ad3 != 5'd0) begin
        m_regs[ad3] = wd3;
        m_pend[ad3] = 1'b0;
      end
      if (issue && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      m_a0 = m_regs[10];
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (a0 !== 32'd0) $display("FAIL reset_a0 got %h want 0", a0); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      ad1 = 5'(i); ad2 = 5'(31 - i);
      #1;
      n_total++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || hazard !== 1'b0)
        $display("FAIL reset_read[%0d] got rd1=%h rd2=%h hz=%b want 0 0 0", i, rd1, rd2, hazard);
      else n_pass++;
    end
    drive(3, 0, 1, 3, 32'h0000CAFE, 1, 3);
    #1;
    n_total++;
    if (rd1 !== 32'h0000CAFE) $display("FAIL reset_bypass got %h want 0000cafe", rd1); else n_pass++;
    tick();
    drive(3, 3, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (rd1 !== 32'd0 || hazard !== 1'b0)
      $display("FAIL reset_write_discarded got rd1=%h hz=%b want 0 0", rd1, hazard);
    else n_pass++;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_bypass();
    drive(5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    #1;
    n_total++;
    if (rd1 !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle got %h want deadbeef", rd1); else n_pass++;
    tick();
    drive(5, 5, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF)
      $display("FAIL bypass_after_edge got rd1=%h rd2=%h want deadbeef", rd1, rd2);
    else n_pass++;
  endtask

  task automatic test_x0();
    drive(0, 0, 1, 0, 32'h12345678, 0, 0);
    #1;
    n_total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL x0_bypass got %h %h want 0 0", rd1, rd2); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    n_total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL x0_write got %h %h want 0 0", rd1, rd2); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b0) $display("FAIL x0_issue_hazard got %b want 0", hazard); else n_pass++;
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 1, 7);
    tick();
    drive(0, 7, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b1) $display("FAIL sb_pending got %b want 1", hazard); else n_pass++;
    drive(0, 7, 1, 7, 32'h55, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b0 || rd2 !== 32'h55)
      $display("FAIL sb_writeback got hz=%b rd2=%h want 0 55", hazard, rd2);
    else n_pass++;
    tick();
    drive(0, 7, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b0 || rd2 !== 32'h55)
      $display("FAIL sb_cleared got hz=%b rd2=%h want 0 55", hazard, rd2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 0, 1, 9);
    tick();
    drive(0, 0, 1, 9, 32'h99, 1, 9);
    tick();
    drive(9, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b1 || rd1 !== 32'h99)
      $display("FAIL set_over_clear got hz=%b rd1=%h want 1 99", hazard, rd1);
    else n_pass++;
  endtask

  task automatic test_a0_async_reset();
    drive(0, 0, 1, 10, 32'h2A, 1, 12);
    tick();
    n_total++;
    if (a0 !== 32'h2A) $display("FAIL a0_update got %h want 2a", a0); else n_pass++;
    drive(10, 12, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (hazard !== 1'b1 || rd1 !== 32'h2A)
      $display("FAIL a0_pre_reset got hz=%b rd1=%h want 1 2a", hazard, rd1);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_total++;
    if (a0 !== 32'd0 || rd1 !== 32'd0) $display("FAIL async_reset got a0=%h rd1=%h want 0 0", a0, rd1); else n_pass++;
    for (int i = 1; i < 32; i++) begin
      ad1 = 5'(i); ad2 = 5'(i);
      #0.1;
      n_total++;
      if (hazard !== 1'b0) $display("FAIL async_reset_pending[%0d] got %b want 0", i, hazard); else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 1'($urandom),
            5'($urandom_range(0, 15)), $urandom, 1'($urandom), 5'($urandom_range(0, 15)));
      #1;
      n_total++;
      if (rd1 !== exp_rd(ad1) || rd2 !== exp_rd(ad2) || hazard !== exp_hz())
        $display("FAIL rand_comb[%0d] got rd1=%h rd2=%h hz=%b want %h %h %b",
                 n, rd1, rd2, hazard, exp_rd(ad1), exp_rd(ad2), exp_hz());
      else n_pass++;
      tick();
      n_total++;
      if (a0 !== m_a0) $display("FAIL rand_a0[%0d] got %h want %h", n, a0, m_a0); else n_pass++;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        n_total++;
        if (a0 !== 32'd0) $display("FAIL rand_reset_a0[%0d] got %h want 0", n, a0); else n_pass++;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_a0_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the RV32I datapath: 2^ADDR_WIDTH registers of DATA_WIDTH bits, two combinational read ports driving the ALU operand inputs and one synchronous write port taking the ALU result back. It also holds a per-register pending scoreboard. The scoreboard marks destinations of issued instructions that have not yet written back, and raises a hazard when an operand read hits one. Together these form the operand-supply and writeback end of the ALU interface.

## Interface

Parameters:
- DATA_WIDTH, 32, register and data-port width
- ADDR_WIDTH, 5, register address width; 32 registers at default

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ad1  in  ADDR_WIDTH  read address, port 1 (rs1)
- ad2  in  ADDR_WIDTH  read address, port 2 (rs2)
- rd1  out  DATA_WIDTH  read data, port 1 (to aluop1)
- rd2  out  DATA_WIDTH  read data, port 2 (to aluop2)
- we3  in  1  write enable
- ad3  in  ADDR_WIDTH  write address (rd)
- wd3  in  DATA_WIDTH  write data (from aluout)
- issue  in  1  instruction issued this cycle; its destination goes pending
- issue_rd  in  ADDR_WIDTH  destination register of the issued instruction
- hazard  out  1  an operand read targets a pending register with no same-cycle bypass
- a0  out  DATA_WIDTH  registered copy of register x10 (debug/testbench observation)

## Operation

- Storage: regs[0..2^ADDR_WIDTH-1] and pending[0..2^ADDR_WIDTH-1].
- Register x0:
  - Reads always return 0.
  - Writes to x0 are discarded.
  - pending[0] is never set.
- Read ports are combinational:
  - If adN == 0, rdN = 0.
  - Else if we3 && ad3 == adN, rdN = wd3 (write-through bypass).
  - Else rdN = regs[adN].
- Write: on the rising edge, if we3 && ad3 != 0, regs[ad3] <= wd3.
- Pending update on the rising edge, applied in this order:
  - Clear: if we3 && ad3 != 0, pending[ad3] <= 0.
  - Set: if issue && issue_rd != 0, pending[issue_rd] <= 1.
  - Set overrides clear for the same register in the same cycle. A new producer issued in the writeback cycle keeps the register pending.
- hazard = (ad1 != 0 && pending[ad1] && !(we3 && ad3 == ad1)) || (ad2 != 0 && pending[ad2] && !(we3 && ad3 == ad2)).
  - A read of a register being written back this cycle is not a hazard, because the bypass supplies the data.
- hazard is advisory only: the block does not stall itself, and writes and issues are accepted regardless of hazard.
- a0 <= value of regs[10] after the current edge's write. This is a registered output, one cycle after the write to x10. When ADDR_WIDTH < 4, a0 is tied to 0.
- A write to a non-pending register is legal and does not change pending.
- Issuing to an already-pending register leaves it pending; there is no counting.

## Timing

- Reset (rst_n low, asynchronous, takes effect immediately and holds):
  - All regs = 0, all pending = 0, a0 = 0.
  - Consequently rd1 = rd2 = 0 and hazard = 0, except that bypass still applies combinationally if we3 is driven.
- Release of rst_n: the first state update occurs on the first rising edge where rst_n is high.
- Read latency 0 (combinational from ad1/ad2/we3/ad3/wd3).
- Write latency 1: data visible via the array on the cycle after the edge, and via bypass in the write cycle itself.
- hazard latency 0 from ad1/ad2. It reflects pending state as of the last edge, qualified by same-cycle writeback.
- Reset asserted mid-operation: all pending and register contents are lost with no completion of in-flight writes. A write whose edge coincides with rst_n low is discarded.

## Test plan

- Reset: drive rst_n=0 with we3=0, then release. Required: rd1=rd2=0 for every address, hazard=0, a0=0.
- Write/read and bypass: we3=1, ad3=5, wd3=0xDEADBEEF, ad1=5 in the same cycle. Required: rd1=0xDEADBEEF before the edge and still after the edge with we3=0.
- x0 protection: we3=1, ad3=0, wd3=0x12345678, then ad1=ad2=0. Required: rd1=rd2=0. issue=1, issue_rd=0 followed by ad1=0 gives hazard=0.
- Scoreboard: issue=1, issue_rd=7; next cycle ad2=7 gives hazard=1. Then we3=1, ad3=7, wd3=0x55 with ad2=7 gives hazard=0 and rd2=0x55 in that cycle; hazard stays 0 afterwards.
- Simultaneous issue and writeback to x9: issue_rd=9, issue=1, we3=1, ad3=9. Required: regs[9] updated, pending[9] remains 1, and hazard=1 on the next cycle with ad1=9, we3=0.
- a0 and async reset: write 0x2A to x10, and a0=0x2A one cycle later. Pulse rst_n low between edges; a0=0, rd of x10 = 0, and all pending cleared immediately without a clock edge.
